// File: rtl/tmds_defs.sv
// Shared TMDS definitions: control-token code words and the receive-side FSM state encoding.
package tmds_defs;

  localparam logic [9:0] TOK_C00 = 10'b1101010100;
  localparam logic [9:0] TOK_C01 = 10'b0010101011;
  localparam logic [9:0] TOK_C10 = 10'b0101010100;
  localparam logic [9:0] TOK_C11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } dec_state_t;

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational TMDS word classifier: control-token detect and 8-bit data decode.
module tmds_word_decode
  import tmds_defs::*;
(
  input  logic [9:0] tmds_in,
  output logic       is_token,
  output logic [1:0] c,
  output logic [7:0] data_byte
);

  logic [7:0] d;

  assign d = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0];

  always_comb begin
    is_token = 1'b1;
    c        = 2'b00;
    case (tmds_in)
      TOK_C00: c = 2'b00;
      TOK_C01: c = 2'b01;
      TOK_C10: c = 2'b10;
      TOK_C11: c = 2'b11;
      default: is_token = 1'b0;
    endcase
  end

  // bit 8 selects whether the encoder chained bits with XOR or XNOR
  always_comb begin
    data_byte    = '0;
    data_byte[0] = d[0];
    for (int unsigned i = 1; i < 8; i++) begin
      data_byte[i] = tmds_in[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: word-boundary alignment via bitslip plus registered data/control decode.
module tmds_channel_decoder
  import tmds_defs::*;
#(
  parameter int unsigned LOCK_RUN      = 8,
  parameter int unsigned SEARCH_CYCLES = 4096,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] tmds_in,
  output logic       bitslip,
  output logic       aligned,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       de
);

  localparam int unsigned RUN_W = $clog2(LOCK_RUN + 1);
  localparam int unsigned WIN_W = $clog2(SEARCH_CYCLES);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(LOCK_RUN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  dec_state_t       state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic [WIN_W-1:0] win_q, win_d;
  logic [SET_W-1:0] set_q, set_d;
  logic             seen_q, seen_d;

  logic       is_token, tok, run_hit, win_end;
  logic [1:0] tok_c;
  logic [7:0] dec_byte;

  tmds_word_decode u_word_decode (
    .tmds_in   (tmds_in),
    .is_token  (is_token),
    .c         (tok_c),
    .data_byte (dec_byte)
  );

  assign tok     = is_token && ((state_q == ST_SEARCH) || (state_q == ST_LOCKED));
  assign run_inc = !tok ? '0 : ((run_q == RUN_MAX) ? run_q : run_q + 1'b1);
  assign run_hit = (run_inc == RUN_MAX);
  assign win_end = (win_q == WIN_LAST);
  assign aligned = (state_q == ST_LOCKED);

  always_comb begin
    state_d = state_q;
    run_d   = run_inc;
    win_d   = win_q + 1'b1;
    seen_d  = seen_q;
    set_d   = '0;
    case (state_q)
      ST_SEARCH: begin
        seen_d = 1'b0;
        // lock takes priority over a simultaneous window expiry
        if (run_hit) begin
          state_d = ST_LOCKED;
          win_d   = '0;
        end else if (win_end) begin
          state_d = ST_SLIP;
          win_d   = '0;
          run_d   = '0;
        end
      end
      ST_SLIP: begin
        state_d = ST_SETTLE;
        run_d   = '0;
        win_d   = '0;
      end
      ST_SETTLE: begin
        run_d = '0;
        win_d = '0;
        set_d = set_q + 1'b1;
        if (set_q == SET_LAST) begin
          state_d = ST_SEARCH;
          set_d   = '0;
        end
      end
      ST_LOCKED: begin
        if (run_hit) seen_d = 1'b1;
        if (win_end) begin
          win_d  = '0;
          seen_d = 1'b0;
          if (!(seen_q || run_hit)) begin
            state_d = ST_SLIP;
            run_d   = '0;
          end
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // outputs are qualified by the state being entered, so the locking token is already decoded
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SEARCH;
      run_q   <= '0;
      win_q   <= '0;
      set_q   <= '0;
      seen_q  <= 1'b0;
      bitslip <= 1'b0;
      data    <= '0;
      ctrl    <= '0;
      de      <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      win_q   <= win_d;
      set_q   <= set_d;
      seen_q  <= seen_d;
      bitslip <= (state_d == ST_SLIP);
      if (state_d == ST_LOCKED) begin
        if (tok) begin
          de   <= 1'b0;
          ctrl <= tok_c;
          data <= '0;
        end else begin
          de   <= 1'b1;
          data <= dec_byte;
        end
      end else begin
        de   <= 1'b0;
        data <= '0;
        ctrl <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: alignment search, decode table, lock keep/loss, reset, window edge.
module tb_tmds_channel_decoder;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] DW  = 10'b0100000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] tmds_in = '0;
  logic       bitslip, aligned, de;
  logic [7:0] data;
  logic [1:0] ctrl;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [9:0] word;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
  } exp_t;

  vec_t tbl[12];
  exp_t sbq[$];

  tmds_channel_decoder #(
    .LOCK_RUN      (8),
    .SEARCH_CYCLES (4096),
    .SETTLE_CYCLES (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tmds_in (tmds_in),
    .bitslip (bitslip),
    .aligned (aligned),
    .data    (data),
    .ctrl    (ctrl),
    .de      (de)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [9:0] w);
    tmds_in = w;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [9:0] w);
    rst = 1'b1;
    tmds_in = w;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [9:0] rotl(input logic [9:0] w, input int unsigned n);
    logic [9:0] r;
    r = w;
    for (int unsigned i = 0; i < (n % 10); i++) r = {r[8:0], r[9]};
    return r;
  endfunction

  initial begin
    #5000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  slips;
    int  last_pulse;
    bit  prev_bs, space_ok, all_aligned, dropped, drop_bs, bs_seen;
    exp_t e;

    tbl[0]  = '{T11,            8'h00, 2'b11, 1'b0};
    tbl[1]  = '{10'b0100000000, 8'h00, 2'b11, 1'b1};
    tbl[2]  = '{10'b1000000000, 8'hFF, 2'b11, 1'b1};
    tbl[3]  = '{T01,            8'h00, 2'b01, 1'b0};
    tbl[4]  = '{10'b0100000001, 8'h03, 2'b01, 1'b1};
    tbl[5]  = '{10'b0000000000, 8'hFE, 2'b01, 1'b1};
    tbl[6]  = '{T10,            8'h00, 2'b10, 1'b0};
    tbl[7]  = '{10'b0110101010, 8'hFE, 2'b10, 1'b1};
    tbl[8]  = '{10'b1100001111, 8'h10, 2'b10, 1'b1};
    tbl[9]  = '{T00,            8'h00, 2'b00, 1'b0};
    tbl[10] = '{10'b0001010101, 8'h01, 2'b00, 1'b1};
    tbl[11] = '{10'b0100110110, 8'h5A, 2'b00, 1'b1};

    // reset state
    do_reset(T00);
    chk("rst_data", data, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_de", de, 0);
    chk("rst_aligned", aligned, 0);
    chk("rst_bitslip", bitslip, 0);

    // already-aligned stream of c=00 tokens
    bs_seen = 0;
    for (int k = 1; k <= 8; k++) begin
      step(T00);
      if (bitslip) bs_seen = 1;
      if (k == 7) chk("t1_aligned_after7", aligned, 0);
    end
    chk("t1_aligned_after8", aligned, 1);
    chk("t1_ctrl", ctrl, 2'b00);
    chk("t1_de", de, 0);
    chk("t1_no_bitslip", bs_seen, 0);

    // misaligned by 3: deserializer model rotates once per bitslip pulse
    do_reset(rotl(T11, 3));
    slips = 0;
    last_pulse = -100000;
    prev_bs = 0;
    space_ok = 1;
    for (int i = 0; i < 40000 && !aligned; i++) begin
      step(rotl(T11, 3 + slips));
      if (bitslip) begin
        if (prev_bs || (i - last_pulse) < 4104) space_ok = 0;
        last_pulse = i;
        slips++;
      end
      prev_bs = bitslip;
    end
    chk("t2_aligned", aligned, 1);
    chk("t2_slips", slips, 7);
    chk("t2_ctrl", ctrl, 2'b11);
    chk("t2_de", de, 0);
    chk("t2_slip_spacing", space_ok, 1);

    // decode table through the scoreboard, while locked
    foreach (tbl[i]) begin
      tmds_in = tbl[i].word;
      sbq.push_back('{tbl[i].data, tbl[i].ctrl, tbl[i].de});
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk($sformatf("dec%0d_data", i), data, e.data);
      chk($sformatf("dec%0d_ctrl", i), ctrl, e.ctrl);
      chk($sformatf("dec%0d_de", i), de, e.de);
    end
    chk("dec_aligned", aligned, 1);

    // periodic token runs keep lock
    all_aligned = 1;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 792; i++) begin
        step(tbl[11].word);
        if (!aligned) all_aligned = 0;
      end
      for (int i = 0; i < 8; i++) begin
        step(T01);
        if (!aligned) all_aligned = 0;
      end
    end
    chk("t4_lock_kept", all_aligned, 1);

    // data only: lock lost at a window end, bitslip on the same edge
    dropped = 0;
    drop_bs = 0;
    for (int i = 0; i < 2 * 4096 + 16 && !dropped; i++) begin
      step(DW);
      if (!aligned) begin
        dropped = 1;
        drop_bs = bitslip;
      end
    end
    chk("t4_lock_dropped", dropped, 1);
    chk("t4_bitslip_at_drop", drop_bs, 1);

    // relock, then reset mid-operation
    for (int i = 0; i < 64 && !aligned; i++) step(T11);
    chk("t5_relocked", aligned, 1);
    step(10'b0100000001);
    chk("t5_pre_data", data, 8'h03);
    chk("t5_pre_de", de, 1);
    do_reset(T11);
    chk("t5_rst_data", data, 0);
    chk("t5_rst_ctrl", ctrl, 0);
    chk("t5_rst_de", de, 0);
    chk("t5_rst_aligned", aligned, 0);
    chk("t5_rst_bitslip", bitslip, 0);
    for (int k = 1; k <= 8; k++) begin
      step(T11);
      if (k == 7) chk("t5_relock_after7", aligned, 0);
    end
    chk("t5_relock_after8", aligned, 1);
    chk("t5_relock_ctrl", ctrl, 2'b11);

    // 8th token lands on the last cycle of the search window: lock wins
    do_reset(DW);
    bs_seen = 0;
    for (int i = 0; i < 4088; i++) begin
      step(DW);
      if (bitslip) bs_seen = 1;
    end
    for (int i = 0; i < 8; i++) begin
      step(T10);
      if (bitslip) bs_seen = 1;
    end
    chk("t6_edge_aligned", aligned, 1);
    chk("t6_edge_ctrl", ctrl, 2'b10);
    chk("t6_edge_no_bitslip", bs_seen, 0);

    // one token short at the window end: slip instead
    do_reset(DW);
    bs_seen = 0;
    for (int i = 0; i < 4089; i++) begin
      step(DW);
      if (bitslip) bs_seen = 1;
    end
    for (int i = 0; i < 6; i++) begin
      step(T10);
      if (bitslip) bs_seen = 1;
    end
    chk("t6_short_no_early_slip", bs_seen, 0);
    step(T10);
    chk("t6_short_bitslip", bitslip, 1);
    chk("t6_short_aligned", aligned, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
